// File: rtl/mask_region_ctrl_if.sv
// Host configuration port of mask_region_ctrl: valid/ready write of one region
// entry, with an optional commit request sampled on the same beat.
interface mask_region_ctrl_if #(
  parameter int unsigned IW = 3
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IW-1:0] cfg_idx;
  logic [9:0]    cfg_x0;
  logic [9:0]    cfg_x1;
  logic [9:0]    cfg_y0;
  logic [9:0]    cfg_y1;
  logic          cfg_on;
  logic          cfg_commit;

  modport master (
    output cfg_valid, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_on, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_on, cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/mask_region_ctrl.sv
// Double-buffered rectangular mask generator with a 2-stage per-pixel pipeline.
// Optional macro MASK_HIT_IDX_EN builds the first-hit region index encoder.
module mask_region_ctrl #(
  parameter int unsigned NREG = 8,
  parameter int unsigned IW   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          tv_x,
  input  logic [9:0]          tv_y,
  input  logic                en,
  input  logic                frame_start,
  mask_region_ctrl_if.slave   cfg,
  output logic                mask,
  output logic [IW-1:0]       hit_idx,
  output logic                pending
);

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
    logic       on;
  } region_t;

  typedef enum logic [1:0] {StIdle, StPending, StSwap} state_e;

  state_e  state_q;
  logic    ready_q;
  logic    pending_q;
  region_t shadow_q [NREG];
  region_t active_q [NREG];

  logic [NREG-1:0] hit_vec;
  logic [NREG-1:0] hit_vec_q;
  logic            en_q;
  logic            mask_q;

  // Control FSM owns both banks; indices >= NREG match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg.cfg_valid) begin
            for (int i = 0; i < NREG; i++) begin
              if (cfg.cfg_idx == IW'(i)) begin
                shadow_q[i] <= '{x0: cfg.cfg_x0, x1: cfg.cfg_x1, y0: cfg.cfg_y0,
                                 y1: cfg.cfg_y1, on: cfg.cfg_on};
              end
            end
            if (cfg.cfg_commit) begin
              state_q   <= StPending;
              ready_q   <= 1'b0;
              pending_q <= 1'b1;
            end
          end
        end
        StPending: begin
          if (frame_start) begin
            state_q <= StSwap;
          end
        end
        StSwap: begin
          for (int i = 0; i < NREG; i++) begin
            active_q[i] <= shadow_q[i];
          end
          state_q   <= StIdle;
          ready_q   <= 1'b1;
          pending_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          ready_q   <= 1'b1;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign pending       = pending_q;

  // Inverted bounds (x0 > x1 or y0 > y1) fail the compare naturally.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      hit_vec[i] = active_q[i].on &&
                   (active_q[i].x0 <= tv_x) && (tv_x <= active_q[i].x1) &&
                   (active_q[i].y0 <= tv_y) && (tv_y <= active_q[i].y1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_vec_q <= '0;
      en_q      <= 1'b0;
      mask_q    <= 1'b0;
    end else begin
      hit_vec_q <= hit_vec;
      en_q      <= en;
      mask_q    <= en_q & (|hit_vec_q);
    end
  end

  assign mask = mask_q;

`ifdef MASK_HIT_IDX_EN
  logic [IW-1:0] hit_enc;
  logic [IW-1:0] hit_idx_q;

  // Descending scan so the lowest-numbered hit is assigned last and wins.
  always_comb begin
    hit_enc = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit_vec_q[i]) begin
        hit_enc = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_idx_q <= '0;
    end else begin
      hit_idx_q <= en_q ? hit_enc : '0;
    end
  end

  assign hit_idx = hit_idx_q;
`else
  assign hit_idx = '0;
`endif

endmodule

// File: tb/tb_mask_region_ctrl.sv
// Directed bench for mask_region_ctrl: pixel expectations come from a bench-side
// bank model, are queued when driven and checked when they leave the pipeline.
module tb_mask_region_ctrl;

  // Index width widened to 4 so an out-of-range index (9) is representable.
  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 4;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
    logic       on;
  } reg_t;

  typedef struct {
    int          due;
    logic        m;
    logic [3:0]  h;
    string       tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    tv_x;
  logic [9:0]    tv_y;
  logic          en;
  logic          frame_start;
  logic          mask;
  logic [IW-1:0] hit_idx;
  logic          pending;

  mask_region_ctrl_if #(.IW(IW)) cfg_bus ();

  mask_region_ctrl #(.NREG(NREG), .IW(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tv_x        (tv_x),
    .tv_y        (tv_y),
    .en          (en),
    .frame_start (frame_start),
    .cfg         (cfg_bus),
    .mask        (mask),
    .hit_idx     (hit_idx),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  reg_t sh [NREG];
  reg_t ac [NREG];
  exp_t sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_px(input logic [9:0] x, input logic [9:0] y, input logic e,
                                   output logic m, output logic [3:0] h);
    m = 1'b0;
    h = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (ac[i].on && ac[i].x0 <= x && x <= ac[i].x1 && ac[i].y0 <= y && y <= ac[i].y1) begin
        m = 1'b1;
        h = 4'(i);
      end
    end
    m = m & e;
`ifdef MASK_HIT_IDX_EN
    if (!m) h = '0;
`else
    h = '0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && sb.size() != 0) begin
      if (sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_mask"}, 32'(mask), 32'(e.m));
        check({e.tag, "_hit_idx"}, 32'(hit_idx), 32'(e.h));
      end else if (sb[0].due < cyc) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_missed"}, cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic e);
    exp_t ex;
    tv_x = x;
    tv_y = y;
    en   = e;
    model_px(x, y, e, ex.m, ex.h);
    ex.due = cyc + 2;
    ex.tag = tag;
    sb.push_back(ex);
    step();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check("sb_drained", 32'(sb.size()), 0);
  endtask

  task automatic cfg_wr(input logic [3:0] idx, input logic [9:0] x0, input logic [9:0] x1,
                        input logic [9:0] y0, input logic [9:0] y1, input logic on,
                        input logic commit, input logic fs);
    check("ready_before_wr", 32'(cfg_bus.cfg_ready), 1);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_idx    = idx;
    cfg_bus.cfg_x0     = x0;
    cfg_bus.cfg_x1     = x1;
    cfg_bus.cfg_y0     = y0;
    cfg_bus.cfg_y1     = y1;
    cfg_bus.cfg_on     = on;
    cfg_bus.cfg_commit = commit;
    frame_start        = fs;
    step();
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
    frame_start        = 1'b0;
    if (idx < NREG) sh[idx] = '{x0: x0, x1: x1, y0: y0, y1: y1, on: on};
  endtask

  // Frame pulse while a commit is pending: expects SWAP next cycle, IDLE after.
  task automatic swap_frame(input string tag);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check({tag, "_swap_pending"}, 32'(pending), 1);
    check({tag, "_swap_ready"}, 32'(cfg_bus.cfg_ready), 0);
    step();
    check({tag, "_idle_pending"}, 32'(pending), 0);
    check({tag, "_idle_ready"}, 32'(cfg_bus.cfg_ready), 1);
    for (int i = 0; i < NREG; i++) ac[i] = sh[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    tv_x = '0;
    tv_y = '0;
    en = 1'b0;
    frame_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_idx = '0;
    cfg_bus.cfg_x0 = '0;
    cfg_bus.cfg_x1 = '0;
    cfg_bus.cfg_y0 = '0;
    cfg_bus.cfg_y1 = '0;
    cfg_bus.cfg_on = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      sh[i] = '0;
      ac[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cfg_bus.cfg_ready), 1);
    check("rst_pending", 32'(pending), 0);
    check("rst_mask", 32'(mask), 0);
    check("rst_hit_idx", 32'(hit_idx), 0);
    #2 rst_n = 1'b1;
    step();

    pix("empty_300_50", 10'd300, 10'd50, 1'b1);
    drain();
    check("post_rst_ready", 32'(cfg_bus.cfg_ready), 1);

    // Region 2 with commit; frame pulse five cycles after the commit beat.
    cfg_wr(4'd2, 10'd200, 10'd400, 10'd10, 10'd150, 1'b1, 1'b1, 1'b0);
    check("commit_pending", 32'(pending), 1);
    check("commit_ready", 32'(cfg_bus.cfg_ready), 0);
    for (int i = 0; i < 4; i++) begin
      check("wait_pending", 32'(pending), 1);
      step();
    end
    swap_frame("r2");
    pix("r2_200_10", 10'd200, 10'd10, 1'b1);
    pix("r2_400_150", 10'd400, 10'd150, 1'b1);
    pix("r2_401_150", 10'd401, 10'd150, 1'b1);
    pix("r2_199_10", 10'd199, 10'd10, 1'b1);
    drain();

    cfg_wr(4'd1, 10'd10, 10'd200, 10'd140, 10'd150, 1'b1, 1'b0, 1'b0);
    cfg_wr(4'd4, 10'd30, 10'd180, 10'd10, 10'd100, 1'b1, 1'b1, 1'b0);
    swap_frame("r14");
    pix("prio_100_145", 10'd100, 10'd145, 1'b1);
    pix("prio_100_50", 10'd100, 10'd50, 1'b1);
    pix("prio_en0", 10'd100, 10'd50, 1'b0);
    drain();

    // Shadow rewrite without commit must not reach the active bank.
    cfg_wr(4'd2, 10'd200, 10'd400, 10'd10, 10'd150, 1'b0, 1'b0, 1'b0);
    pix("shadow_only_a", 10'd300, 10'd50, 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("idle_frame_pending", 32'(pending), 0);
    pix("shadow_only_b", 10'd300, 10'd50, 1'b1);
    drain();
    cfg_wr(4'd2, 10'd200, 10'd400, 10'd10, 10'd150, 1'b0, 1'b1, 1'b0);
    swap_frame("r2off");
    pix("r2off_300_50", 10'd300, 10'd50, 1'b1);
    drain();

    // Commit beat coincides with frame_start: that pulse must not trigger the swap.
    cfg_wr(4'd3, 10'd0, 10'd10, 10'd0, 10'd10, 1'b1, 1'b1, 1'b1);
    check("coinc_pending", 32'(pending), 1);
    step();
    check("coinc_still_pending", 32'(pending), 1);
    check("coinc_ready", 32'(cfg_bus.cfg_ready), 0);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idx = 4'd3;
    cfg_bus.cfg_on = 1'b0;
    cfg_bus.cfg_x0 = 10'd900;
    step();
    check("pend_wr_ready", 32'(cfg_bus.cfg_ready), 0);
    step();
    cfg_bus.cfg_valid = 1'b0;
    pix("pre_swap_5_5", 10'd5, 10'd5, 1'b1);
    drain();
    swap_frame("r3");
    pix("r3_5_5", 10'd5, 10'd5, 1'b1);
    drain();

    // Inverted region 0 and an out-of-range index covering the whole screen.
    cfg_wr(4'd0, 10'd500, 10'd400, 10'd10, 10'd20, 1'b1, 1'b0, 1'b0);
    cfg_wr(4'd9, 10'd0, 10'd1023, 10'd0, 10'd1023, 1'b1, 1'b1, 1'b0);
    check("oor_commit_pending", 32'(pending), 1);
    swap_frame("oor");
    pix("inv_450_15", 10'd450, 10'd15, 1'b1);
    pix("oor_600_600", 10'd600, 10'd600, 1'b1);
    pix("oor_r1_intact", 10'd100, 10'd145, 1'b1);
    pix("oor_r4_intact", 10'd100, 10'd50, 1'b1);
    drain();

    // Reset while a commit is pending, with a live hitting pixel in flight.
    cfg_wr(4'd5, 10'd0, 10'd1023, 10'd0, 10'd1023, 1'b1, 1'b1, 1'b0);
    pix("pre_rst_a", 10'd100, 10'd50, 1'b1);
    pix("pre_rst_b", 10'd100, 10'd50, 1'b1);
    drain();
    check("pre_rst_live_mask", 32'(mask), 1);
    check("pre_rst_pending", 32'(pending), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mask", 32'(mask), 0);
    check("mid_rst_hit_idx", 32'(hit_idx), 0);
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_ready", 32'(cfg_bus.cfg_ready), 1);
    for (int i = 0; i < NREG; i++) begin
      sh[i] = '0;
      ac[i] = '0;
    end
    en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    pix("post_rst_100_50", 10'd100, 10'd50, 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("post_rst_no_pending", 32'(pending), 0);
    step();
    pix("post_rst_frame_100_50", 10'd100, 10'd50, 1'b1);
    pix("post_rst_frame_5_5", 10'd5, 10'd5, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mask_region_ctrl.md
# mask_region_ctrl

Programmable, double-buffered rectangular mask generator and controller for the video counting path. Holds NREG inclusive-bound rectangles, accepts host updates through a valid/ready write port into a shadow bank, and swaps them into the active bank only at a frame boundary. Produces a registered per-pixel mask (plus first-hit region index) from the raster coordinates for the downstream fish-detection logic.

## Interface
- NREG, 8, number of rectangles (1..16)
- IW, 3, region index width, ceil(log2(NREG))
- clk  in  1  system/pixel clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- tv_x  in  10  raster column
- tv_y  in  10  raster row
- en  in  1  mask enable for current pixel
- frame_start  in  1  single-cycle pulse at start of frame
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accepted when valid&ready
- cfg_idx  in  IW  target region
- cfg_x0, cfg_x1, cfg_y0, cfg_y1  in  10 each  inclusive bounds
- cfg_on  in  1  region enable bit
- cfg_commit  in  1  request shadow→active swap (sampled with the handshake)
- mask  out  1  pixel inside any enabled active region
- hit_idx  out  IW  lowest-numbered region hit
- pending  out  1  commit accepted, swap not yet done

## Operation
- Two banks of NREG entries {x0,x1,y0,y1,on}: shadow (host-written) and active (used by scan).
- FSM: IDLE → PENDING → SWAP → IDLE.
  - IDLE: cfg_ready=1. Accepted write stores fields into shadow[cfg_idx]. If cfg_commit=1 on an accepted beat, write applies first, then → PENDING.
  - PENDING: cfg_ready=0, pending=1. On frame_start → SWAP. frame_start in the same cycle as the commit beat does not count.
  - SWAP: one cycle; all NREG shadow entries copied to active; pending cleared on exit; cfg_ready=0 this cycle.
- cfg_idx ≥ NREG: handshake completes, no entry written; commit still honoured.
- Hit for region i: on & x0≤tv_x≤x1 & y0≤tv_y≤y1, unsigned. x0>x1 or y0>y1 never hits.
- mask = en & OR(hit_i). hit_idx = lowest i with hit_i, else 0; forced 0 when mask=0.
- Active bank unaffected by shadow writes until SWAP.

## Timing
- Reset (async assert, sync release): both banks all-zero (on=0), FSM IDLE, cfg_ready=1, pending=0, mask=0, hit_idx=0, pipeline registers 0.
- Mask pipeline latency 2 cycles: stage 1 registers per-region compare results and en; stage 2 registers OR-reduction and priority encode. Coordinates at cycle n → mask/hit_idx valid at n+2.
- Pixels sampled in SWAP cycle use the old active bank at stage 1; from SWAP+1 onward, new bank.
- Commit-to-swap: commit beat at n, frame_start at m>n → SWAP at m+1, pending=0 and cfg_ready=1 at m+2.
- Reset mid-PENDING discards the commit; shadow contents lost.
- Throughput: one pixel per cycle, no stalls; en=0 pixels still advance pipeline.

## Configuration
- MASK_HIT_IDX_EN defined: priority encoder and hit_idx register built as above.
- Not defined: no encoder logic; hit_idx tied to 0; mask behaviour and latency unchanged.

## Test plan
- Reset, then scan (300,50) with en=1 → mask=0, hit_idx=0 two cycles later; cfg_ready=1.
- Write region 2 = {200,400,10,150,on} with commit, frame_start 5 cycles later → pending high until SWAP; (200,10),(400,150) give mask=1, (401,150) and (199,10) give mask=0, all at 2-cycle latency.
- Regions 1 {10,200,140,150} and 4 {30,180,10,100} active; pixel (100,145) → hit_idx=1; (100,50) → hit_idx=4; same pixel with en=0 → mask=0, hit_idx=0.
- After swap, rewrite region 2 to off without commit → mask still 1 at (300,50) across frames; commit + frame_start → mask 0.
- Commit coinciding with frame_start → no swap that cycle; swap on next frame_start; cfg_valid during PENDING sees cfg_ready=0, shadow unchanged.
- Region {500,400,10,20,on} and cfg_idx=9 write (NREG=8) → never hits, no entry corrupted; assert rst_n low during PENDING → pending=0, mask=0 immediately, active bank cleared.
